// File: rtl/krz_xbar_mn.sv
// krz_xbar_mn: NM-master x NS-slave crossbar with per-slave arbitration,
// address decode, unmapped-address errors and an optional ack timeout.
module krz_xbar_mn #(
   parameter int NM = 2,
   parameter int NS = 4,
   parameter int AW = 24,
   parameter int ARB_RR = 0,
   parameter int TIMEOUT = 0,
   parameter logic [NS*AW-1:0] SLV_BASE = '0,
   parameter logic [NS*AW-1:0] SLV_MASK = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM*32-1:0] m_wr_data,
   input  logic [NM*4-1:0]  m_mask,
   input  logic [NM-1:0]    m_wr_en,
   input  logic [NM-1:0]    m_req,
   output logic [NM*32-1:0] m_rd_data,
   output logic [NM-1:0]    m_ack,
   output logic [NM-1:0]    m_err,
   output logic [NS*AW-1:0] s_adr,
   output logic [NS*32-1:0] s_dat_o,
   output logic [NS*4-1:0]  s_sel,
   output logic [NS-1:0]    s_we,
   output logic [NS-1:0]    s_stb,
   input  logic [NS*32-1:0] s_dat_i,
   input  logic [NS-1:0]    s_ack
);
   localparam int OW = NM > 1 ? $clog2(NM) : 1;
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        st   [NS];
   logic [OW-1:0] own  [NS];
   logic [OW-1:0] ptr  [NS];
   logic [OW-1:0] win  [NS];
   logic [CW-1:0] cnt  [NS];
   logic [NM-1:0] sreq [NS];
   logic [NM-1:0] err_q, hit, tmo;
   logic [NS-1:0] act, fire, expire;
   // first requester found when searching b, b+1, ... modulo NM
   function automatic logic [OW-1:0] pick(input logic [NM-1:0] r, input int b);
      pick = '0;
      for (int k = NM - 1; k >= 0; k--)
         if (|((r >> ((b + k) % NM)) & NM'(1))) pick = OW'((b + k) % NM);
   endfunction
   always_comb begin
      hit = '0;
      tmo = '0;
      for (int j = 0; j < NS; j++) sreq[j] = '0;
      for (int i = 0; i < NM; i++)
         for (int j = 0; j < NS; j++)
            if (!hit[i] && (m_addr[i*AW +: AW] & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW]) begin
               hit[i] = 1'b1;
               sreq[j][i] = m_req[i] & ~err_q[i];
            end
      for (int j = 0; j < NS; j++) begin
         act[j] = st[j] == BUSY && !rst;
         fire[j] = act[j] & s_ack[j];
         expire[j] = act[j] && !s_ack[j] && TIMEOUT > 0 && int'(cnt[j]) == TIMEOUT - 1;
         win[j] = pick(sreq[j], ARB_RR != 0 ? int'(ptr[j]) : 0);
         for (int i = 0; i < NM; i++)
            if (expire[j] && int'(own[j]) == i) tmo[i] = 1'b1;
      end
   end
   always_comb begin
      m_ack = err_q & ~{NM{rst}};
      m_err = m_ack;
      m_rd_data = '0;
      s_stb = act;
      s_adr = '0;
      s_dat_o = '0;
      s_sel = '0;
      s_we = '0;
      for (int j = 0; j < NS; j++)
         for (int i = 0; i < NM; i++)
            if (int'(own[j]) == i) begin
               s_adr[j*AW +: AW] = m_addr[i*AW +: AW];
               s_dat_o[j*32 +: 32] = m_wr_data[i*32 +: 32];
               s_sel[j*4 +: 4] = m_mask[i*4 +: 4];
               s_we[j] = m_wr_en[i];
               if (fire[j]) begin
                  m_ack[i] = 1'b1;
                  m_rd_data[i*32 +: 32] = s_dat_i[j*32 +: 32];
               end
            end
   end
   // error flags hold the one-cycle error ack and keep that master out of arbitration meanwhile
   always_ff @(posedge clk)
      if (rst) begin
         err_q <= '0;
         for (int j = 0; j < NS; j++) begin
            st[j] <= IDLE;
            own[j] <= '0;
            ptr[j] <= '0;
            cnt[j] <= '0;
         end
      end else begin
         err_q <= (m_req & ~hit & ~err_q) | tmo;
         for (int j = 0; j < NS; j++)
            if (st[j] == IDLE) begin
               if (|sreq[j]) begin
                  st[j] <= BUSY;
                  own[j] <= win[j];
                  cnt[j] <= '0;
                  ptr[j] <= OW'((int'(win[j]) + 1) % NM);
               end
            end else if (fire[j] || expire[j]) st[j] <= IDLE;
            else cnt[j] <= cnt[j] + 1'b1;
      end
endmodule
